// File: rtl/addsub16_seq.sv
// Sequential 16-bit two's-complement adder/subtractor built around a single
// 4-bit add/sub slice, processing one nibble per clock from LSB to MSB.

module addsub4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [4:0] full;
    logic [3:0] low;

    assign full = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    // Carry into the slice MSB, needed for signed overflow on the top nibble.
    assign low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
    assign s    = full[3:0];
    assign co   = full[4];
    assign c3   = low[3];
endmodule

module addsub16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        ovf
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        op_sub;
    logic        c;
    logic [1:0]  idx;
    logic [11:0] sh;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  slice_s;
    logic        slice_c3;
    logic        slice_co;
    logic        accept;

    assign nib_a  = opa[{idx, 2'b00} +: 4];
    assign nib_b  = op_sub ? ~opb[{idx, 2'b00} +: 4] : opb[{idx, 2'b00} +: 4];
    assign accept = (state == IDLE) && start;

    addsub4_slice u_slice (
        .x   (nib_a),
        .y   (nib_b),
        .cin (c),
        .s   (slice_s),
        .c3  (slice_c3),
        .co  (slice_co)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (idx == 2'd3) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            op_sub <= 1'b0;
            c      <= 1'b0;
            idx    <= '0;
            sh     <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            opa    <= a;
            opb    <= b;
            op_sub <= sub;
            c      <= sub;
            idx    <= '0;
        end else if (state == RUN) begin
            c   <= slice_co;
            idx <= idx + 2'd1;
            case (idx)
                2'd0: sh[3:0]  <= slice_s;
                2'd1: sh[7:4]  <= slice_s;
                2'd2: sh[11:8] <= slice_s;
                default: begin
                    // Last nibble: publish the whole result in one step.
                    result <= {slice_s, sh};
                    cout   <= slice_co;
                    ovf    <= slice_c3 ^ slice_co;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_addsub16_seq.sv
// Directed self-checking bench for addsub16_seq with hand-computed vectors.

module tb_addsub16_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fails  = 0;

    addsub16_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; n counts edges taken, busy_n counts busy cycles.
    task automatic wait_done(input int max, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < max) begin
            if (busy === 1'b1) busy_n++;
            step();
            n++;
        end
        if (busy === 1'b1) busy_n++;
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic [15:0] er, input logic ec, input logic eo);
        int n;
        int bn;
        a = va; b = vb; sub = vs; start = 1'b1;
        step();                         // accept edge E0
        start = 1'b0;
        wait_done(20, n, bn);
        check({tag, "_latency"}, n, 4);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        step();                         // E5
        check({tag, "_busy_cycles"}, bn, 5);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int n;
        int bn;
        int dn;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 16'h0000);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        step();

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Ignored start with changed operands, then start held high.
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        step();                         // E0
        start = 1'b0;
        step();
        step();                         // E2
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        check("ign_busy", busy, 1);
        wait_done(20, n, bn);
        check("ign_latency", n, 2);
        check("ign_result", result, 16'h0002);
        check("ign_cout", cout, 0);
        dn = 0;
        n = 0;
        step();
        n++;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("held_gap", n, 6);
        check("held_result", result, 16'hFFFE);
        check("held_cout", cout, 1);
        check("held_ovf", ovf, 0);
        start = 1'b0;
        step();
        step();

        // Reset mid-operation (rst together with start to show priority).
        run_op("pre_rst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        step();                         // E0
        start = 1'b0;
        step();
        step();                         // two nibbles registered
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 16'h0000);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            step();
        end
        check("mid_rst_quiet", dn, 0);
        run_op("post_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
